ps2_key_dispatcher: RTL and testbench

//  - Receives PS/2 keyboard frames in the clk domain and decodes make/break/extended scancodes.
//  - Keeps a held-key bitmap and routes keys to the menu (one-shot pulses) or to two player

---
 rtl/ps2_key_dispatcher_pkg.sv | 73 +++++++
 rtl/ps2_key_dispatcher_if.sv | 28 ++
 rtl/ps2_frame_rx.sv | 120 ++++++++++++
 rtl/ps2_key_dispatcher.sv | 98 +++++++++
 tb/tb_ps2_key_dispatcher.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/ps2_key_dispatcher_pkg.sv
// Shared scancodes, key indices and the scancode lookup
// used by the PS/2 receiver and key dispatcher.
package ps2_key_dispatcher_pkg;

    typedef logic [7:0] scan_t;
    typedef logic [3:0] kidx_t;
    typedef logic [4:0] keys_t;

    // Scancodes
    localparam scan_t SC_E0 = 8'hE0;
    localparam scan_t SC_F0 = 8'hF0;
    localparam scan_t SC_1D = 8'h1D;
    localparam scan_t SC_1B = 8'h1B;
    localparam scan_t SC_1C = 8'h1C;
    localparam scan_t SC_23 = 8'h23;
    localparam scan_t SC_29 = 8'h29;
    localparam scan_t SC_5A = 8'h5A;
    localparam scan_t SC_75 = 8'h75;
    localparam scan_t SC_72 = 8'h72;
    localparam scan_t SC_6B = 8'h6B;
    localparam scan_t SC_74 = 8'h74;

    // Key index within one player's 5-bit group
    localparam kidx_t KEY_UP    = 4'd0;
    localparam kidx_t KEY_DOWN  = 4'd1;
    localparam kidx_t KEY_LEFT  = 4'd2;
    localparam kidx_t KEY_RIGHT = 4'd3;
    localparam kidx_t KEY_BOMB  = 4'd4;

    // Bitmap: player 1 in [4:0], player 2 in [9:5]
    localparam kidx_t P2_BASE = 4'd5;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    typedef struct packed {
        logic  hit;
        kidx_t idx;
    } key_hit_t;

    function automatic key_hit_t key_lookup(
        input logic  ext,
        input scan_t code
    );
        key_hit_t r;
        r = '{hit: 1'b0, idx: '0};
        if (!ext) begin
            case (code)
                SC_1D: r = '{hit: 1'b1, idx: KEY_UP};
                SC_1B: r = '{hit: 1'b1, idx: KEY_DOWN};
                SC_1C: r = '{hit: 1'b1, idx: KEY_LEFT};
                SC_23: r = '{hit: 1'b1, idx: KEY_RIGHT};
                SC_29: r = '{hit: 1'b1, idx: KEY_BOMB};
                SC_5A: r = '{hit: 1'b1, idx: P2_BASE + KEY_BOMB};
                default: r = '{hit: 1'b0, idx: '0};
            endcase
        end else begin
            case (code)
                SC_75: r = '{hit: 1'b1, idx: P2_BASE + KEY_UP};
                SC_72: r = '{hit: 1'b1, idx: P2_BASE + KEY_DOWN};
                SC_6B: r = '{hit: 1'b1, idx: P2_BASE + KEY_LEFT};
                SC_74: r = '{hit: 1'b1, idx: P2_BASE + KEY_RIGHT};
                default: r = '{hit: 1'b0, idx: '0};
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/ps2_key_dispatcher_if.sv
// Bundle of PS/2 pins, game mode and dispatched key outputs.
// master drives pins/mode; slave is the dispatcher.
interface ps2_key_dispatcher_if;
    import ps2_key_dispatcher_pkg::*;

    logic  ps2_clk;
    logic  ps2_dat;
    logic  mode;
    logic  menu_up;
    logic  menu_down;
    logic  menu_enter;
    keys_t p1_keys;
    keys_t p2_keys;
    logic  frame_err;

    modport master (
        output ps2_clk, ps2_dat, mode,
        input  menu_up, menu_down, menu_enter,
        input  p1_keys, p2_keys, frame_err
    );

    modport slave (
        input  ps2_clk, ps2_dat, mode,
        output menu_up, menu_down, menu_enter,
        output p1_keys, p2_keys, frame_err
    );

endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: pin sync, falling-edge detect, 11-bit frame FSM, timeout.
// Ports: clk, rst_n, ps2_clk, ps2_dat in; rx_byte, byte_vld, frame_err, flush out.
module ps2_frame_rx
    import ps2_key_dispatcher_pkg::*;
#(
    parameter int TIMEOUT_CYC = 200000,
    parameter int SYNC_STAGES = 2
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  ps2_clk,
    input  logic  ps2_dat,
    output scan_t rx_byte,
    output logic  byte_vld,
    output logic  frame_err,
    output logic  flush
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic                   clk_prev;

    rx_state_t     state, state_n;
    scan_t         shreg, shreg_n;
    logic [2:0]    cnt, cnt_n;
    logic          par, par_n;
    logic [TW-1:0] tmo, tmo_n;
    logic          vld_n, err_n, flush_n;

    logic fall;
    logic bit_in;

    assign fall   = clk_prev & ~clk_sync[SYNC_STAGES-1];
    assign bit_in = dat_sync[SYNC_STAGES-1];

    // Sync flops reset high (idle bus) so no false edge leaves reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clk_sync  <= '1;
            dat_sync  <= '1;
            clk_prev  <= 1'b1;
            state     <= RX_IDLE;
            shreg     <= '0;
            cnt       <= '0;
            par       <= 1'b0;
            tmo       <= '0;
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
            flush     <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            dat_sync  <= {dat_sync[SYNC_STAGES-2:0], ps2_dat};
            clk_prev  <= clk_sync[SYNC_STAGES-1];
            state     <= state_n;
            shreg     <= shreg_n;
            cnt       <= cnt_n;
            par       <= par_n;
            tmo       <= tmo_n;
            byte_vld  <= vld_n;
            frame_err <= err_n;
            flush     <= flush_n;
        end
    end

    always_comb begin
        state_n = state;
        shreg_n = shreg;
        cnt_n   = cnt;
        par_n   = par;
        vld_n   = 1'b0;
        err_n   = 1'b0;
        flush_n = 1'b0;
        tmo_n   = (state == RX_IDLE || fall) ? '0 : tmo + 1'b1;

        unique case (state)
            RX_IDLE: if (fall) begin
                if (!bit_in) begin
                    state_n = RX_DATA;
                    cnt_n   = '0;
                    par_n   = 1'b0;
                end else begin
                    err_n = 1'b1;
                end
            end
            RX_DATA: if (fall) begin
                shreg_n = {bit_in, shreg[7:1]};
                par_n   = par ^ bit_in;
                if (cnt == 3'd7) state_n = RX_PARITY;
                else             cnt_n   = cnt + 3'd1;
            end
            RX_PARITY: if (fall) begin
                par_n   = par ^ bit_in;
                state_n = RX_STOP;
            end
            RX_STOP: if (fall) begin
                state_n = RX_IDLE;
                if (bit_in && par) begin
                    vld_n = 1'b1;
                end else begin
                    err_n   = 1'b1;
                    flush_n = 1'b1;
                end
            end
            default: state_n = RX_IDLE;
        endcase

        if (state != RX_IDLE && !fall && tmo == TMO_LAST) begin
            state_n = RX_IDLE;
            tmo_n   = '0;
            err_n   = 1'b1;
            flush_n = 1'b1;
        end
    end

    assign rx_byte = shreg;

endmodule

// File: rtl/ps2_key_dispatcher.sv
// PS/2 key dispatcher: prefix decode, held-key bitmap, menu pulses, player levels.
// Ports: clk, rst_n, bus (slave: ps2 pins, mode in; menu pulses, p1/p2 keys, frame_err out).
module ps2_key_dispatcher
    import ps2_key_dispatcher_pkg::*;
#(
    parameter int TIMEOUT_CYC = 200000,
    parameter int SYNC_STAGES = 2
) (
    input logic                 clk,
    input logic                 rst_n,
    ps2_key_dispatcher_if.slave bus
);

    scan_t    rx_byte;
    logic     byte_vld;
    logic     frame_err;
    logic     flush;
    logic     mode_q;
    logic     ext, brk;
    logic [9:0] bitmap;
    logic     up_q, down_q, enter_q;
    key_hit_t kh;

    ps2_frame_rx #(
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_rx (
        .clk      (clk),
        .rst_n    (rst_n),
        .ps2_clk  (bus.ps2_clk),
        .ps2_dat  (bus.ps2_dat),
        .rx_byte  (rx_byte),
        .byte_vld (byte_vld),
        .frame_err(frame_err),
        .flush    (flush)
    );

    assign kh = key_lookup(ext, rx_byte);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q  <= bus.mode;
            ext     <= 1'b0;
            brk     <= 1'b0;
            bitmap  <= '0;
            up_q    <= 1'b0;
            down_q  <= 1'b0;
            enter_q <= 1'b0;
        end else begin
            mode_q  <= bus.mode;
            up_q    <= 1'b0;
            down_q  <= 1'b0;
            enter_q <= 1'b0;
            // A mode switch wipes state and swallows any byte arriving with it
            if (bus.mode != mode_q) begin
                bitmap <= '0;
                ext    <= 1'b0;
                brk    <= 1'b0;
            end else if (flush) begin
                ext <= 1'b0;
                brk <= 1'b0;
            end else if (byte_vld) begin
                unique case (1'b1)
                    (rx_byte == SC_E0): ext <= 1'b1;
                    (rx_byte == SC_F0): brk <= 1'b1;
                    default: begin
                        ext <= 1'b0;
                        brk <= 1'b0;
                        if (kh.hit) begin
                            if (brk) begin
                                bitmap[kh.idx] <= 1'b0;
                            end else if (!bitmap[kh.idx]) begin
                                // Only a fresh press pulses, so typematic repeat is ignored
                                bitmap[kh.idx] <= 1'b1;
                                if (!bus.mode) begin
                                    up_q <= (kh.idx == KEY_UP)
                                         || (kh.idx == P2_BASE + KEY_UP);
                                    down_q <= (kh.idx == KEY_DOWN)
                                           || (kh.idx == P2_BASE + KEY_DOWN);
                                    enter_q <= (kh.idx == KEY_BOMB)
                                            || (kh.idx == P2_BASE + KEY_BOMB);
                                end
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign bus.menu_up    = up_q;
    assign bus.menu_down  = down_q;
    assign bus.menu_enter = enter_q;
    assign bus.p1_keys    = bus.mode ? bitmap[4:0] : '0;
    assign bus.p2_keys    = bus.mode ? bitmap[9:5] : '0;
    assign bus.frame_err  = frame_err;

endmodule

// File: tb/tb_ps2_key_dispatcher.sv
// Directed table-driven bench for ps2_key_dispatcher.
// Frames are bit-banged on ps2_clk/ps2_dat; pulses are counted on negedge.
module tb_ps2_key_dispatcher;
    import ps2_key_dispatcher_pkg::*;

    localparam int TMO  = 300;
    localparam int HALF = 8;

    typedef struct {
        logic [7:0] code;
        bit         good;
        int         d_up;
        int         d_dn;
        int         d_en;
        int         d_er;
        logic [4:0] p1;
        logic [4:0] p2;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ps2_key_dispatcher_if bus();

    ps2_key_dispatcher #(
        .TIMEOUT_CYC(TMO),
        .SYNC_STAGES(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    int n_up = 0, n_dn = 0, n_en = 0, n_er = 0;
    int tests = 0, fails = 0;
    vec_t vt[22];

    always @(negedge clk) begin
        if (bus.menu_up)    n_up++;
        if (bus.menu_down)  n_dn++;
        if (bus.menu_enter) n_en++;
        if (bus.frame_err)  n_er++;
    end

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit good,
                              input int nbits);
        logic [10:0] f;
        f = {1'b1, good ? ~^b : ^b, b, 1'b0};
        for (int k = 0; k < nbits; k++) begin
            bus.ps2_dat = f[k];
            repeat (HALF) @(negedge clk);
            bus.ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            bus.ps2_clk = 1'b1;
        end
        bus.ps2_dat = 1'b1;
    endtask

    task automatic run_vec(input int i);
        int u, d, e, r;
        u = n_up; d = n_dn; e = n_en; r = n_er;
        send_frame(vt[i].code, vt[i].good, 11);
        repeat (12) @(negedge clk);
        check($sformatf("v%0d_up", i), n_up - u, vt[i].d_up);
        check($sformatf("v%0d_down", i), n_dn - d, vt[i].d_dn);
        check($sformatf("v%0d_enter", i), n_en - e, vt[i].d_en);
        check($sformatf("v%0d_err", i), n_er - r, vt[i].d_er);
        check($sformatf("v%0d_p1", i), int'(bus.p1_keys), int'(vt[i].p1));
        check($sformatf("v%0d_p2", i), int'(bus.p2_keys), int'(vt[i].p2));
    endtask

    task automatic set_mode(input logic m);
        bus.mode = m;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int e0, u0;
        // mode 0: repeat suppression, parity error, then menu down
        vt[0]  = '{8'h1D, 1, 1, 0, 0, 0, 5'h00, 5'h00};
        vt[1]  = '{8'h1D, 1, 0, 0, 0, 0, 5'h00, 5'h00};
        vt[2]  = '{8'hF0, 1, 0, 0, 0, 0, 5'h00, 5'h00};
        vt[3]  = '{8'h1D, 1, 0, 0, 0, 0, 5'h00, 5'h00};
        vt[4]  = '{8'h5A, 0, 0, 0, 0, 1, 5'h00, 5'h00};
        vt[5]  = '{8'h5A, 1, 0, 0, 1, 0, 5'h00, 5'h00};
        vt[6]  = '{8'h1B, 1, 0, 1, 0, 0, 5'h00, 5'h00};
        // mode 1: extended keys, bare 74 ignored, player 1 holds
        vt[7]  = '{8'hE0, 1, 0, 0, 0, 0, 5'h00, 5'h00};
        vt[8]  = '{8'h74, 1, 0, 0, 0, 0, 5'h00, 5'h08};
        vt[9]  = '{8'hE0, 1, 0, 0, 0, 0, 5'h00, 5'h08};
        vt[10] = '{8'hF0, 1, 0, 0, 0, 0, 5'h00, 5'h08};
        vt[11] = '{8'h74, 1, 0, 0, 0, 0, 5'h00, 5'h00};
        vt[12] = '{8'h74, 1, 0, 0, 0, 0, 5'h00, 5'h00};
        vt[13] = '{8'hF0, 1, 0, 0, 0, 0, 5'h00, 5'h00};
        vt[14] = '{8'h74, 1, 0, 0, 0, 0, 5'h00, 5'h00};
        vt[15] = '{8'h1D, 1, 0, 0, 0, 0, 5'h01, 5'h00};
        vt[16] = '{8'h29, 1, 0, 0, 0, 0, 5'h11, 5'h00};
        // after mode toggle
        vt[17] = '{8'hF0, 1, 0, 0, 0, 0, 5'h00, 5'h00};
        vt[18] = '{8'h1D, 1, 0, 0, 0, 0, 5'h00, 5'h00};
        vt[19] = '{8'h29, 1, 0, 0, 0, 0, 5'h10, 5'h00};
        // after mid-frame reset, mode 0
        vt[20] = '{8'hE0, 1, 0, 0, 0, 0, 5'h00, 5'h00};
        vt[21] = '{8'h75, 1, 1, 0, 0, 0, 5'h00, 5'h00};

        bus.ps2_clk = 1'b1;
        bus.ps2_dat = 1'b1;
        bus.mode    = 1'b0;
        rst_n       = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_up", int'(bus.menu_up), 0);
        check("rst_p1", int'(bus.p1_keys), 0);
        check("rst_p2", int'(bus.p2_keys), 0);
        check("rst_err", int'(bus.frame_err), 0);

        for (int i = 0; i <= 5; i++) run_vec(i);

        // partial frame left hanging must time out
        e0 = n_er; u0 = n_dn;
        send_frame(8'h1B, 1, 5);
        repeat (TMO / 2) @(negedge clk);
        check("tmo_early", n_er - e0, 0);
        repeat (TMO / 2 + 40) @(negedge clk);
        check("tmo_err", n_er - e0, 1);
        check("tmo_nodown", n_dn - u0, 0);

        run_vec(6);

        // entering game mode clears the held 5A / 1B
        set_mode(1'b1);
        check("mode1_p2", int'(bus.p2_keys), 0);
        check("mode1_p1", int'(bus.p1_keys), 0);

        for (int i = 7; i <= 16; i++) run_vec(i);

        set_mode(1'b0);
        check("tog0_p1", int'(bus.p1_keys), 0);
        set_mode(1'b1);
        check("tog1_p1", int'(bus.p1_keys), 0);

        for (int i = 17; i <= 19; i++) run_vec(i);

        // reset in the middle of DATA
        e0 = n_er;
        send_frame(8'h5A, 1, 5);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_p1", int'(bus.p1_keys), 0);
        check("mid_rst_p2", int'(bus.p2_keys), 0);
        set_mode(1'b0);
        repeat (TMO + 40) @(negedge clk);
        check("mid_rst_noerr", n_er - e0, 0);

        for (int i = 20; i <= 21; i++) run_vec(i);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
